// File: rtl/cpu_wb_pkg.sv
// rtl/cpu_wb_pkg.sv - shared writeback widths, entry type and register-zero index
package cpu_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// rtl/wb_entry_fifo.sv - circular {rd, data} buffer with occupancy and full entry visibility
module wb_entry_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_push,
  input  logic [ADDR_W-1:0]                i_push_rd,
  input  logic [DATA_W-1:0]                i_push_data,
  input  logic                             i_pop,
  output logic [PTR_W-1:0]                 o_head,
  output logic [CNT_W-1:0]                 o_count,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]     o_rd_all,
  output logic [DEPTH-1:0][DATA_W-1:0]     o_data_all
);

  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [DEPTH-1:0][ADDR_W-1:0] r_rd;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy separately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents are not reset; only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_tail]   <= i_push_rd;
      r_data[r_tail] <= i_push_data;
    end
  end

  assign o_head     = r_head;
  assign o_count    = r_count;
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_rd_all   = r_rd;
  assign o_data_all = r_data;

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - in-order writeback queue with load-priority arbitration and forwarding
module wb_commit_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cpu_wb_pkg::DATA_W,
  parameter int ADDR_W = cpu_wb_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_rd,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    wb_hold,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       writeback_address,
  output logic [DATA_W-1:0]       writeback_data,
  input  logic [ADDR_W-1:0]       rs_1,
  input  logic [ADDR_W-1:0]       rs_2,
  output logic                    fwd_hit_1,
  output logic                    fwd_hit_2,
  output logic [DATA_W-1:0]       fwd_data_1,
  output logic [DATA_W-1:0]       fwd_data_2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  import cpu_wb_pkg::REG_ZERO;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                         w_pop;
  logic                         w_space;
  logic                         w_push;
  logic                         w_store;
  logic [ADDR_W-1:0]            w_push_rd;
  logic [DATA_W-1:0]            w_push_data;
  logic [PTR_W-1:0]             w_head;
  logic [CNT_W-1:0]             w_count;
  logic                         w_full;
  logic                         w_empty;
  logic [DEPTH-1:0][ADDR_W-1:0] w_rd_all;
  logic [DEPTH-1:0][DATA_W-1:0] w_data_all;
  logic [1:0][ADDR_W-1:0]       w_rs;
  logic [1:0]                   w_hit;
  logic [1:0][DATA_W-1:0]       w_fwd;

  // Drain is blocked while reset is low so nothing reaches the register file.
  assign w_pop     = reset && !w_empty && !wb_hold;
  // A full queue still has room when its head leaves this cycle.
  assign w_space   = !w_full || w_pop;
  assign ld_ready  = reset && w_space;
  assign alu_ready = reset && w_space && !ld_valid;

  // Load wins; when the ALU is granted ld_valid is low, so the mux follows ld_valid.
  assign w_push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign w_push_rd   = ld_valid ? ld_rd : alu_rd;
  assign w_push_data = ld_valid ? ld_data : alu_data;
  // Writes to x0 complete the handshake but are dropped here.
  assign w_store     = w_push && (w_push_rd != ADDR_W'(REG_ZERO));

  wb_entry_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_store),
    .i_push_rd   (w_push_rd),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_rd_all    (w_rd_all),
    .o_data_all  (w_data_all)
  );

  assign write_enable      = w_pop;
  assign writeback_address = w_pop ? w_rd_all[w_head]   : '0;
  assign writeback_data    = w_pop ? w_data_all[w_head] : '0;

  assign count = w_count;
  assign full  = w_full;
  assign empty = w_empty;

  assign w_rs = {rs_2, rs_1};

  // Walk live entries oldest to youngest; later matches overwrite, so the youngest wins.
  always_comb begin
    w_hit = '0;
    w_fwd = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < w_count) && (w_rs[p] != ADDR_W'(REG_ZERO)) &&
            (w_rd_all[w_head + PTR_W'(i)] == w_rs[p])) begin
          w_hit[p] = 1'b1;
          w_fwd[p] = w_data_all[w_head + PTR_W'(i)];
        end
      end
    end
  end

  assign fwd_hit_1  = w_hit[0];
  assign fwd_hit_2  = w_hit[1];
  assign fwd_data_1 = w_fwd[0];
  assign fwd_data_2 = w_fwd[1];

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - directed vector table plus randomized queue-model checks
module tb_wb_commit_queue;
  import cpu_wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              ldv, aluv, hold;
  logic [ADDR_W-1:0] ldrd, alurd, rs1, rs2;
  logic [DATA_W-1:0] ldd, alud;
  logic              ld_ready, alu_ready, write_enable, fwd_hit_1, fwd_hit_2, full, empty;
  logic [ADDR_W-1:0] writeback_address;
  logic [DATA_W-1:0] writeback_data, fwd_data_1, fwd_data_2;
  logic [$clog2(DEPTH):0] count;

  wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(rst),
    .ld_valid(ldv), .ld_rd(ldrd), .ld_data(ldd), .ld_ready(ld_ready),
    .alu_valid(aluv), .alu_rd(alurd), .alu_data(alud), .alu_ready(alu_ready),
    .wb_hold(hold), .write_enable(write_enable),
    .writeback_address(writeback_address), .writeback_data(writeback_data),
    .rs_1(rs1), .rs_2(rs2), .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .count(count), .full(full), .empty(empty)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ldv; logic [4:0] ldrd; logic [31:0] ldd;
    logic aluv; logic [4:0] alurd; logic [31:0] alud;
    logic hold; logic [4:0] rs1, rs2;
    logic we; logic [4:0] wa; logic [31:0] wd; logic ldr, alur; int cnt;
    logic h1; logic [31:0] f1; logic h2; logic [31:0] f2;
  } vec_t;

  vec_t tbl[$];

  task automatic t(input logic r, input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                   input logic av, input logic [4:0] ard, input logic [31:0] ad, input logic hd,
                   input logic [4:0] s1, input logic [4:0] s2,
                   input logic we, input logic [4:0] wa, input logic [31:0] wd,
                   input logic lr, input logic ar, input int c,
                   input logic h1, input logic [31:0] f1, input logic h2, input logic [31:0] f2);
    vec_t v;
    v.rst = r; v.ldv = lv; v.ldrd = lrd; v.ldd = ld; v.aluv = av; v.alurd = ard; v.alud = ad;
    v.hold = hd; v.rs1 = s1; v.rs2 = s2; v.we = we; v.wa = wa; v.wd = wd; v.ldr = lr;
    v.alur = ar; v.cnt = c; v.h1 = h1; v.f1 = f1; v.h2 = h2; v.f2 = f2;
    tbl.push_back(v);
  endtask

  wb_entry_t q[$];

  // One cycle against the queue model: check combinational outputs, clock, then update the model.
  task automatic model_cycle(input string tag);
    bit pop, space, lr, ar;
    bit h[2];
    logic [DATA_W-1:0] fd[2];
    logic [ADDR_W-1:0] rsv[2];
    wb_entry_t e;
    #2;
    pop   = rst && (q.size() > 0) && !hold;
    space = (q.size() < DEPTH) || pop;
    lr    = rst && space;
    ar    = lr && !ldv;
    rsv[0] = rs1; rsv[1] = rs2;
    for (int p = 0; p < 2; p++) begin
      h[p] = 0; fd[p] = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (!h[p] && rsv[p] != 0 && q[i].rd == rsv[p]) begin h[p] = 1; fd[p] = q[i].data; end
    end
    chk({tag, "_we"},    write_enable, pop);
    chk({tag, "_waddr"}, writeback_address, pop ? q[0].rd : '0);
    chk({tag, "_wdata"}, writeback_data, pop ? q[0].data : '0);
    chk({tag, "_ldr"},   ld_ready, lr);
    chk({tag, "_alur"},  alu_ready, ar);
    chk({tag, "_count"}, count, q.size());
    chk({tag, "_full"},  full, q.size() == DEPTH);
    chk({tag, "_empty"}, empty, q.size() == 0);
    chk({tag, "_hit1"},  fwd_hit_1, h[0]);
    chk({tag, "_fwd1"},  fwd_data_1, fd[0]);
    chk({tag, "_hit2"},  fwd_hit_2, h[1]);
    chk({tag, "_fwd2"},  fwd_data_2, fd[1]);
    @(posedge clk); #1;
    if (!rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (ldv && lr) begin
        e.rd = ldrd; e.data = ldd;
        if (ldrd != 0) q.push_back(e);
      end else if (aluv && ar) begin
        e.rd = alurd; e.data = alud;
        if (alurd != 0) q.push_back(e);
      end
    end
  endtask

  task automatic idle_inputs();
    ldv = 0; ldrd = 0; ldd = 0; aluv = 0; alurd = 0; alud = 0; hold = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    //   rst ldv rd  data         aluv rd data  hold rs1 rs2 | we wa wd          ldr alur cnt h1 f1           h2 f2
    t(0, 1, 3, 32'h1,        0, 0, 0,     0, 3, 0,   0, 0, 0,            0, 0, 0, 0, 0,            0, 0);
    t(1, 1, 3, 32'hA5A50001, 0, 0, 0,     0, 3, 0,   0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 3, 3,   1, 3, 32'hA5A50001, 1, 1, 1, 1, 32'hA5A50001, 1, 32'hA5A50001);
    t(1, 0, 0, 0,            0, 0, 0,     0, 3, 0,   0, 0, 0,            1, 1, 0, 0, 0,            0, 0);
    t(1, 1, 4, 32'h44,       1, 5, 32'h55, 0, 0, 0,  0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            1, 5, 32'h55, 0, 4, 5,  1, 4, 32'h44,       1, 1, 1, 1, 32'h44,       0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 4, 5,   1, 5, 32'h55,       1, 1, 1, 0, 0,            1, 32'h55);
    t(1, 0, 0, 0,            0, 0, 0,     0, 0, 0,   0, 0, 0,            1, 1, 0, 0, 0,            0, 0);
    t(1, 1, 7, 32'h1,        0, 0, 0,     1, 0, 0,   0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            1, 7, 32'h2, 1, 7, 0,   0, 0, 0,            1, 1, 1, 1, 32'h1,        0, 0);
    t(1, 1, 8, 32'h3,        0, 0, 0,     1, 7, 0,   0, 0, 0,            1, 0, 2, 1, 32'h2,        0, 0);
    t(1, 0, 0, 0,            1, 9, 32'h4, 1, 8, 0,   0, 0, 0,            1, 1, 3, 1, 32'h3,        0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     1, 7, 9,   0, 0, 0,            0, 0, 4, 1, 32'h2,        1, 32'h4);
    t(1, 1, 10, 32'hAA,      0, 0, 0,     0, 7, 8,   1, 7, 32'h1,        1, 0, 4, 1, 32'h2,        1, 32'h3);
    t(1, 0, 0, 0,            0, 0, 0,     0, 10, 7,  1, 7, 32'h2,        1, 1, 4, 1, 32'hAA,       1, 32'h2);
    t(1, 0, 0, 0,            0, 0, 0,     0, 7, 0,   1, 8, 32'h3,        1, 1, 3, 0, 0,            0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 0, 0,   1, 9, 32'h4,        1, 1, 2, 0, 0,            0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 10, 0,  1, 10, 32'hAA,      1, 1, 1, 1, 32'hAA,       0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 0, 0,   0, 0, 0,            1, 1, 0, 0, 0,            0, 0);
    t(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0,     0, 0, 0,   0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 0, 0,   0, 0, 0,            1, 1, 0, 0, 0,            0, 0);
    t(1, 1, 1, 32'h11,       0, 0, 0,     1, 0, 0,   0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            1, 2, 32'h22, 1, 0, 0,  0, 0, 0,            1, 1, 1, 0, 0,            0, 0);
    t(1, 1, 3, 32'h33,       0, 0, 0,     1, 0, 0,   0, 0, 0,            1, 0, 2, 0, 0,            0, 0);
    t(0, 1, 6, 32'h66,       0, 0, 0,     0, 0, 0,   0, 0, 0,            0, 0, 3, 0, 0,            0, 0);
    t(1, 1, 12, 32'hC,       0, 0, 0,     0, 12, 1,  0, 0, 0,            1, 0, 0, 0, 0,            0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 12, 0,  1, 12, 32'hC,       1, 1, 1, 1, 32'hC,        0, 0);
    t(1, 0, 0, 0,            0, 0, 0,     0, 0, 0,   0, 0, 0,            1, 1, 0, 0, 0,            0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; ldv = tbl[k].ldv; ldrd = tbl[k].ldrd; ldd = tbl[k].ldd;
      aluv = tbl[k].aluv; alurd = tbl[k].alurd; alud = tbl[k].alud; hold = tbl[k].hold;
      rs1 = tbl[k].rs1; rs2 = tbl[k].rs2;
      #2;
      chk($sformatf("v%0d_we", k),    write_enable, tbl[k].we);
      chk($sformatf("v%0d_waddr", k), writeback_address, tbl[k].wa);
      chk($sformatf("v%0d_wdata", k), writeback_data, tbl[k].wd);
      chk($sformatf("v%0d_ldr", k),   ld_ready, tbl[k].ldr);
      chk($sformatf("v%0d_alur", k),  alu_ready, tbl[k].alur);
      chk($sformatf("v%0d_count", k), count, tbl[k].cnt);
      chk($sformatf("v%0d_full", k),  full, tbl[k].cnt == DEPTH);
      chk($sformatf("v%0d_empty", k), empty, tbl[k].cnt == 0);
      chk($sformatf("v%0d_hit1", k),  fwd_hit_1, tbl[k].h1);
      chk($sformatf("v%0d_fwd1", k),  fwd_data_1, tbl[k].f1);
      chk($sformatf("v%0d_hit2", k),  fwd_hit_2, tbl[k].h2);
      chk($sformatf("v%0d_fwd2", k),  fwd_data_2, tbl[k].f2);
      @(posedge clk); #1;
    end

    // Queue is empty after the table; start the model from a clean reset.
    idle_inputs();
    rst = 0;
    model_cycle("rst");
    rst = 1;

    // Alternating sources with continuous drain: occupancy stays at most one.
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin ldv = 1; ldrd = 5'(k % 7 + 1); ldd = $urandom; end
      else begin aluv = 1; alurd = 5'(k % 5 + 10); alud = $urandom; end
      rs1 = 5'(k % 7 + 1);
      model_cycle($sformatf("alt%0d", k));
      chk($sformatf("alt%0d_count_le1", k), count <= 1, 1'b1);
    end

    for (int k = 0; k < 300; k++) begin
      ldv   = ($urandom_range(0, 99) < 50);
      ldrd  = 5'($urandom_range(0, 7));
      ldd   = $urandom;
      aluv  = ($urandom_range(0, 99) < 50);
      alurd = 5'($urandom_range(0, 7));
      alud  = $urandom;
      hold  = ($urandom_range(0, 99) < 35);
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      model_cycle($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Writeback commit queue between the execute/memory stages and the register file write port. Accepts results from the ALU and load paths over valid/ready handshakes and buffers them in a small in-order FIFO. Drains one entry per cycle into the register file's single write port (`writeback_address`/`writeback_data`/`write_enable`). Provides combinational forwarding of still-pending results to the two register read ports.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- DATA_W, 32, result width
- ADDR_W, 5, register index width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- ld_valid  in  1  load result valid
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load result
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- alu_valid  in  1  ALU result valid
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- wb_hold  in  1  suppress drain this cycle
- write_enable  out  1  register file write strobe
- writeback_address  out  ADDR_W  register file write index
- writeback_data  out  DATA_W  register file write data
- rs_1, rs_2  in  ADDR_W  read indices, mirrored from the register file read ports
- fwd_hit_1, fwd_hit_2  out  1  a pending entry targets rs_n
- fwd_data_1, fwd_data_2  out  DATA_W  youngest pending data for rs_n; 0 when no hit
- count  out  $clog2(DEPTH)+1  occupancy
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Storage: circular buffer of {rd, data}; head and tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; separate count register.
- pop = !empty && !wb_hold. write_enable = pop. writeback_address and writeback_data come from the head entry when pop is high and are 0 otherwise.
- space = !full || pop: a full queue accepts a push in the same cycle it drains.
- Arbitration: at most one push per cycle; load has fixed priority. ld_ready = space. alu_ready = space && !ld_valid.
- Pushes to register 0: the handshake completes but no entry is stored, and count is unchanged.
- Count update: push && pop leaves count unchanged; push only increments it; pop only decrements it.
- Forwarding:
  - For each read index, search valid entries youngest (tail-1) to oldest (head) for a matching rd; an index of 0 never hits.
  - On a hit, return the youngest matching data.
  - The head entry being written this cycle is still searched.
  - Incoming same-cycle pushes are not searched.
- During reset (reset==0):
  - ld_ready, alu_ready and write_enable are forced to 0.
  - At the clock edge, pointers and count go to 0 and all entries are discarded. Entry contents need not be cleared.
- Reset outputs: write_enable 0, writeback_address 0, writeback_data 0, fwd_hit_n 0, fwd_data_n 0, count 0, empty 1, full 0, ld_ready 0, alu_ready 0.

## Timing
- Ready signals, write outputs and forwarding outputs are combinational from state and inputs. Storage and pointers are registered.
- Latency: a result accepted at edge N is presented on the write port from cycle N+1 (after edge N) and lands in the register file at edge N+1 if wb_hold is low.
- Throughput: one push and one pop per cycle sustained.
- Ordering: FIFO. Writes reach the register file in acceptance order, so the last write to an index wins.
- The register file must be clocked on the same clk with its write enabled by write_enable. Its reset input is tied to the same reset.

## Structure
- Shared package cpu_wb_pkg holds:
  - ADDR_W and DATA_W constants
  - typedef wb_entry_t {rd, data}
  - REG_ZERO = 0
- One sub-module, wb_entry_fifo: storage, pointers, count, full/empty, plus read access to every entry for the forwarding search.
- wb_commit_queue contains arbitration, x0 filtering, the write port and the forwarding priority search.

## Test plan
- Reset, then ld_valid=1, ld_rd=3, ld_data=0xA5A5_0001 for one cycle → write_enable=1, writeback_address=3, writeback_data=0xA5A5_0001 on the next cycle; empty=1 after it.
- ld_valid and alu_valid both high for one cycle (rd 4 and 5) → ld_ready=1, alu_ready=0; hold alu_valid → reg 4 is written, then reg 5, on consecutive cycles.
- wb_hold=1 with 4 pushes to rd 7, 7, 8, 9 (data 1, 2, 3, 4) → full=1, count=4; rs_1=7 gives fwd_hit_1=1 with data 2. Release hold → writes to 7, 7, 8, 9 in that order. A push is accepted on the first drain cycle while full.
- Push to rd 0 with data 0xFFFF_FFFF → handshake completes, count stays 0, write_enable stays 0, and rs_1=0 gives no hit.
- Hold the queue at count 3, then assert reset for one edge → count=0, write_enable=0, ready signals low while reset is low; the first push after release writes correctly.
- Continuous push plus drain alternating across both sources for 20 cycles → write order equals acceptance order, count never exceeds 1, and the pointers wrap cleanly.
